// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation scheduler.
package irrigation_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_SUSPEND = 2'd3
  } state_t;

  typedef enum logic {
    ZONE_SPRINKLER = 1'b0,
    ZONE_DRIP      = 1'b1
  } zone_t;

  // Round-robin pick between the two zones given the current requests.
  function automatic zone_t pick_zone(input logic req_s, input logic req_d, input zone_t last);
    if (req_s && req_d) return (last == ZONE_DRIP) ? ZONE_SPRINKLER : ZONE_DRIP;
    return req_s ? ZONE_SPRINKLER : ZONE_DRIP;
  endfunction

endpackage

// File: rtl/irrigation_scheduler_bcd_down_digit.sv
// One BCD digit of a loadable down-counter; load wins over decrement.
module bcd_down_digit
  import irrigation_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             zero,
  output logic             borrow
);

  logic [BCD_W-1:0] q_q, q_d;

  // Next digit value: load, else 0 -> 9 wrap on decrement, else hold.
  always_comb begin
    q_d = q_q;
    if (load)           q_d = load_val;
    else if (dec)       q_d = (q_q == '0) ? BCD_W'(9) : q_q - BCD_W'(1);
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q      = q_q;
  assign zero   = (q_q == '0);
  // Borrow is raw (ignores load) so the next digit's decrement depends only on dec and q.
  assign borrow = dec & zero;

endmodule

// File: rtl/irrigation_scheduler.sv
// Two-zone irrigation scheduler sharing one 2-digit BCD countdown timer.
// state   | meaning
// IDLE    | waiting for a request with water available
// RUN     | granted valve open, counting down run time
// PAUSE   | valves closed, counting down settle time
// SUSPEND | tank low during a run; count frozen
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter logic [7:0] SPRINKLER_TIME = 8'h30,
  parameter logic [7:0] DRIP_TIME      = 8'h45,
  parameter logic [7:0] PAUSE_TIME     = 8'h05
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             req_sprinkler,
  input  logic             req_drip,
  input  logic             water_ok,
  input  logic             abort,
  output logic             valve_sprinkler,
  output logic             valve_drip,
  output logic             busy,
  output logic             fault,
  output logic             done,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_units
);

  state_t state_q, state_d;
  zone_t  grant_q, grant_d, last_q, last_d, winner;
  logic   done_d;
  logic   cnt_load;
  logic [7:0] cnt_load_val;
  logic   dec_req;
  logic [BCD_W-1:0] units_q, tens_q;
  logic   units_zero, units_borrow, tens_zero, tens_borrow;
  logic   count_one, count_end;
  logic   valve_sprinkler_q, valve_drip_q, busy_q, fault_q, done_q;

  // Decrement request is independent of the terminal decision; a coinciding load wins in the digit.
  assign dec_req = tick_1hz & ~abort &
                   (((state_q == ST_RUN) & water_ok) | (state_q == ST_PAUSE));

  bcd_down_digit u_units (
    .clk(clk), .reset(reset), .load(cnt_load), .load_val(cnt_load_val[3:0]), .dec(dec_req),
    .q(units_q), .zero(units_zero), .borrow(units_borrow)
  );

  bcd_down_digit u_tens (
    .clk(clk), .reset(reset), .load(cnt_load), .load_val(cnt_load_val[7:4]), .dec(units_borrow),
    .q(tens_q), .zero(tens_zero), .borrow(tens_borrow)
  );

  // 01 is the normal end of a countdown; a decrement at 00 is also ended so the count never wraps.
  assign count_one = tens_zero & ~units_zero & (units_q[3:1] == 3'd0);
  assign count_end = count_one | tens_borrow;

  // Next state, arbitration and counter load control.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = 8'h00;
    winner       = pick_zone(req_sprinkler, req_drip, last_q);
    if (abort) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (water_ok && (req_sprinkler || req_drip)) begin
            state_d      = ST_RUN;
            grant_d      = winner;
            last_d       = winner;
            cnt_load     = 1'b1;
            cnt_load_val = (winner == ZONE_SPRINKLER) ? SPRINKLER_TIME : DRIP_TIME;
          end
        end
        ST_RUN: begin
          if (!water_ok) begin
            state_d = ST_SUSPEND;
          end else if (tick_1hz && count_end) begin
            state_d      = ST_PAUSE;
            done_d       = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = PAUSE_TIME;
          end
        end
        ST_SUSPEND: begin
          if (water_ok) state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (tick_1hz && count_end) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers and outputs registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      grant_q           <= ZONE_DRIP;
      last_q            <= ZONE_DRIP;
      valve_sprinkler_q <= 1'b0;
      valve_drip_q      <= 1'b0;
      busy_q            <= 1'b0;
      fault_q           <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      grant_q           <= grant_d;
      last_q            <= last_d;
      valve_sprinkler_q <= (state_d == ST_RUN) & (grant_d == ZONE_SPRINKLER);
      valve_drip_q      <= (state_d == ST_RUN) & (grant_d == ZONE_DRIP);
      busy_q            <= (state_d != ST_IDLE);
      fault_q           <= (state_d == ST_SUSPEND);
      done_q            <= done_d;
    end
  end

  assign valve_sprinkler = valve_sprinkler_q;
  assign valve_drip      = valve_drip_q;
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign done            = done_q;
  assign bcd_tens        = tens_q;
  assign bcd_units       = units_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with hand-computed expectations.
module tb_irrigation_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_1hz = 1'b0;
  logic req_sprinkler = 1'b0;
  logic req_drip = 1'b0;
  logic water_ok = 1'b0;
  logic abort = 1'b0;
  logic valve_sprinkler, valve_drip, busy, fault, done;
  logic [3:0] bcd_tens, bcd_units;

  int checks = 0;
  int errors = 0;

  irrigation_scheduler dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .req_sprinkler(req_sprinkler), .req_drip(req_drip),
    .water_ok(water_ok), .abort(abort),
    .valve_sprinkler(valve_sprinkler), .valve_drip(valve_drip),
    .busy(busy), .fault(fault), .done(done),
    .bcd_tens(bcd_tens), .bcd_units(bcd_units)
  );

  always #5 clk = ~clk;

  // Observed vector: {valve_s, valve_d, busy, fault, done, tens, units}
  wire [12:0] obs = {valve_sprinkler, valve_drip, busy, fault, done, bcd_tens, bcd_units};

  function automatic logic [12:0] ev(input logic vs, input logic vd, input logic bz,
                                     input logic ft, input logic dn, input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {vs, vd, bz, ft, dn, t, u};
  endfunction

  task automatic chk(input string tag, input logic [12:0] o, input logic [12:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  // One clock with optional tick; returns 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick_1hz = t;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs, ev(0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // Both requesting after reset: sprinkler first; tick on the load edge is consumed.
    req_sprinkler = 1'b1; req_drip = 1'b1; water_ok = 1'b1;
    cyc(1'b1);
    chk("load_tick_30", obs, ev(1, 0, 1, 0, 0, 30));
    for (int n = 29; n >= 1; n--) begin
      cyc(1'b1);
      chk("spr_run", obs, ev(1, 0, 1, 0, 0, n));
    end
    cyc(1'b1);
    chk("spr_done", obs, ev(0, 0, 1, 0, 1, 5));
    for (int n = 4; n >= 1; n--) begin
      cyc(1'b1);
      chk("pause1", obs, ev(0, 0, 1, 0, 0, n));
    end
    cyc(1'b1);
    chk("pause1_end", obs, ev(0, 0, 0, 0, 0, 0));

    // Alternation: drip next.
    cyc(1'b0);
    chk("drip_grant", obs, ev(0, 1, 1, 0, 0, 45));
    for (int n = 44; n >= 1; n--) begin
      cyc(1'b1);
      chk("drip_run", obs, ev(0, 1, 1, 0, 0, n));
    end
    cyc(1'b1);
    chk("drip_done", obs, ev(0, 0, 1, 0, 1, 5));
    for (int n = 4; n >= 1; n--) begin
      cyc(1'b1);
      chk("pause2", obs, ev(0, 0, 1, 0, 0, n));
    end
    cyc(1'b1);
    chk("pause2_end", obs, ev(0, 0, 0, 0, 0, 0));

    // Back to sprinkler.
    cyc(1'b0);
    chk("spr_again", obs, ev(1, 0, 1, 0, 0, 30));
    req_drip = 1'b0;
    for (int n = 29; n >= 17; n--) begin
      cyc(1'b1);
      chk("spr_run2", obs, ev(1, 0, 1, 0, 0, n));
    end

    // Low tank at 17: tick in the same cycle ignored.
    water_ok = 1'b0;
    cyc(1'b1);
    chk("suspend", obs, ev(0, 0, 1, 1, 0, 17));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("suspend_hold", obs, ev(0, 0, 1, 1, 0, 17));
    end
    water_ok = 1'b1;
    cyc(1'b0);
    chk("resume", obs, ev(1, 0, 1, 0, 0, 17));
    cyc(1'b1);
    chk("resume_tick", obs, ev(1, 0, 1, 0, 0, 16));
    for (int n = 15; n >= 1; n--) begin
      cyc(1'b1);
      chk("spr_run3", obs, ev(1, 0, 1, 0, 0, n));
    end
    req_sprinkler = 1'b0;
    cyc(1'b1);
    chk("spr_done3", obs, ev(0, 0, 1, 0, 1, 5));
    cyc(1'b1);
    chk("pause3_04", obs, ev(0, 0, 1, 0, 0, 4));
    cyc(1'b1);
    chk("pause3_03", obs, ev(0, 0, 1, 0, 0, 3));

    // Abort during PAUSE at 03.
    abort = 1'b1;
    cyc(1'b1);
    chk("abort", obs, ev(0, 0, 0, 0, 0, 0));
    cyc(1'b1);
    chk("abort_idle", obs, ev(0, 0, 0, 0, 0, 0));

    // No water in IDLE keeps the request pending.
    water_ok = 1'b0; req_sprinkler = 1'b1;
    cyc(1'b0);
    chk("idle_no_water", obs, ev(0, 0, 0, 0, 0, 0));
    water_ok = 1'b1;
    cyc(1'b0);
    chk("idle_water_back", obs, ev(1, 0, 1, 0, 0, 30));

    // Dropping the request mid-run does not stop the run.
    req_sprinkler = 1'b0;
    cyc(1'b1);
    chk("req_drop_run", obs, ev(1, 0, 1, 0, 0, 29));

    // Asynchronous reset mid-run.
    #3 reset = 1'b1;
    #1 chk("async_reset", obs, ev(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 chk("reset_held", obs, ev(0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    req_sprinkler = 1'b1; req_drip = 1'b1;
    cyc(1'b0);
    chk("post_reset_spr", obs, ev(1, 0, 1, 0, 0, 30));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
